pu_array_sequencer: RTL
=======================

// Module: pu_array_sequencer
// PURPOSE
//  Sequences an array of img2col PUs.
//  - Accepts pixel words on a valid/ready stream and scatters them into each PU's new-data regfile.
//  - Fires the PU array once per round and collects per-PU completion flags.
//  - Steps the round counter until the programmed number of rounds is done.
//  - Sits between the AXI-side input buffer and the PU array; drives the array's shared control inputs.
// PARAMETERS
//  data_width  16  pixel word width
//  address_num 5   PU regfile address width
//  pu_num      5   number of PUs sequenced (1..32)
//  ksize       5   kernel column height = words loaded per PU in round 0 (1..2**address_num)
// PORTS
//  clk               in   1            system clock, rising edge
//  rst               in   1            asynchronous reset, active-high
//  cfg_start         in   1            one-cycle pulse: begin a job; ignored while busy
//  cfg_rounds        in   6            number of rounds in the job; 0 is treated as 1
//  s_valid           in   1            input pixel valid
//  s_data            in   data_width   input pixel
//  s_ready           out  1            sequencer accepts s_data this cycle
//  pu_new1           out  data_width   broadcast write data to all PUs (= s_data)
//  pu_wr_g           out  pu_num       one-hot write enable into a PU's new regfile
//  pu_adrs_in1       out  address_num  regfile write address
//  pu_adrs_in2       out  address_num  regfile read bound, constant ksize-1
//  pu_start          out  1            one-cycle fire pulse to all PUs
//  pu_round          out  6            current round index
//  pu_act            out  1            array active; high while busy
//  pu_neighbour_flag out  1            PUs take neighbour data; high in FIRE when round>0
//  pu_t_flag         in   pu_num       per-PU round-complete pulse or level
//  busy              out  1            job in progress
//  done              out  1            one-cycle pulse when the job completes
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, round=0, pu_idx=0, addr=0, sticky flags=0.
//   All outputs 0 except pu_adrs_in2=ksize-1.
//  IDLE: latch rounds_q=max(cfg_rounds,1) on cfg_start; go to LOAD.
//  LOAD: s_ready=1. A word is accepted when s_valid&&s_ready, in the same cycle:
//   - pu_new1=s_data; pu_wr_g=1<<pu_idx; pu_adrs_in1=addr (combinational, zero latency).
//   - pu_wr_g=0 whenever no word is accepted.
//  Round 0 fill:
//   - addr runs 0..ksize-1 for each PU.
//   - pu_idx runs 0..pu_num-1; addr wraps to 0 and pu_idx increments.
//   - pu_num*ksize words in total.
//  Rounds >0 fill:
//   - One word per PU at addr=ksize-1; pu_idx runs 0..pu_num-1.
//   - pu_num words in total; the remaining data comes from neighbours.
//  After the last accepted word: pu_idx=0, addr=0; next state FIRE. s_ready drops the following cycle.
//  FIRE, one cycle:
//   - pu_start=1, pu_round=round, pu_neighbour_flag=(round!=0).
//   - Clear the sticky done vector; go to WAIT.
//  WAIT:
//   - sticky[i] |= pu_t_flag[i].
//   - When sticky (including this cycle's flags) is all-ones, go to NEXT.
//   - t_flag arriving during FIRE is ignored.
//  NEXT, one cycle:
//   - If round==rounds_q-1: round=0, go to DONE.
//   - Else: round+=1, go to LOAD.
//  DONE, one cycle: done=1; go to IDLE.
//  busy=1 and pu_act=1 in every state except IDLE.
//  pu_round holds its value in all states. round is 6-bit, so a 63-round job never wraps.
//  cfg_start while busy: ignored, no effect on counters.
//  s_valid outside LOAD: word not accepted; the source must hold it.
//  Reset mid-job: job aborted immediately. No done pulse. A fresh cfg_start is required.
// TESTING
//  1. pu_num=5, ksize=5, cfg_rounds=1, s_valid held 1, data=0..24:
//     25 writes, data k goes to pu_wr_g=1<<(k/5), adrs_in1=k%5.
//     Then pu_start pulse, neighbour_flag=0; all t_flag -> done one cycle after NEXT.
//  2. cfg_rounds=3: round 1 and round 2 each take exactly 5 writes at adrs_in1=4.
//     pu_round=1,2 at the FIRE pulses; neighbour_flag=1; done after third completion.
//  3. Staggered t_flag pulses (PU0 at +2, PU4 at +9, others between):
//     NEXT is entered only on the cycle the last flag arrives; no early fire.
//  4. s_valid toggling 1010... during LOAD: pu_wr_g asserted only on accepted cycles.
//     No address skip; still 25 writes.
//  5. cfg_rounds=0 -> behaves as 1 round.
//     cfg_start pulsed during WAIT -> ignored, round unchanged.
//  6. rst asserted mid-LOAD (word 12) -> all outputs 0, busy=0 immediately.
//     A new job restarts at PU0 addr0.

Source files
------------

// File: rtl/pu_array_sequencer_if.sv
// Control/stream bundle between the img2col PU array sequencer and its neighbours.
// slave = sequencer side, master = environment (input buffer, PU array, job control).
interface pu_array_sequencer_if #(
    parameter int data_width  = 16,
    parameter int address_num = 5,
    parameter int pu_num      = 5
);
    logic                   cfg_start;
    logic [5:0]             cfg_rounds;
    logic                   s_valid;
    logic [data_width-1:0]  s_data;
    logic                   s_ready;
    logic [data_width-1:0]  pu_new1;
    logic [pu_num-1:0]      pu_wr_g;
    logic [address_num-1:0] pu_adrs_in1;
    logic [address_num-1:0] pu_adrs_in2;
    logic                   pu_start;
    logic [5:0]             pu_round;
    logic                   pu_act;
    logic                   pu_neighbour_flag;
    logic [pu_num-1:0]      pu_t_flag;
    logic                   busy;
    logic                   done;

    modport slave (
        input  cfg_start, cfg_rounds, s_valid, s_data, pu_t_flag,
        output s_ready, pu_new1, pu_wr_g, pu_adrs_in1, pu_adrs_in2, pu_start,
               pu_round, pu_act, pu_neighbour_flag, busy, done
    );

    modport master (
        output cfg_start, cfg_rounds, s_valid, s_data, pu_t_flag,
        input  s_ready, pu_new1, pu_wr_g, pu_adrs_in1, pu_adrs_in2, pu_start,
               pu_round, pu_act, pu_neighbour_flag, busy, done
    );
endinterface

// File: rtl/pu_array_sequencer.sv
// Scatters streamed pixels into the PU regfiles, fires the array once per round, collects completion.
// Latency: regfile write is combinational on the accepting cycle; FIRE follows the last word by one cycle.
// Backpressure: s_ready is high only in LOAD; the source holds s_data in every other state.
module pu_array_sequencer #(
    parameter int data_width  = 16,
    parameter int address_num = 5,
    parameter int pu_num      = 5,
    parameter int ksize       = 5
) (
    input  logic clk,
    input  logic rst,
    pu_array_sequencer_if.slave bus
);
    localparam int idx_width = (pu_num > 1) ? $clog2(pu_num) : 1;
    localparam logic [address_num-1:0] last_addr = address_num'(ksize - 1);
    localparam logic [idx_width-1:0]   last_idx  = idx_width'(pu_num - 1);
    localparam logic [pu_num-1:0]      all_done  = '1;
    localparam logic [pu_num-1:0]      pu0_sel   = pu_num'(1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        FIRE = 3'd2,
        WAIT = 3'd3,
        NEXT = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [5:0]             round;
    logic [5:0]             rounds_q;
    logic [idx_width-1:0]   pu_idx;
    logic [address_num-1:0] addr;
    logic [pu_num-1:0]      sticky;
    logic [pu_num-1:0]      sticky_nxt;
    logic                   accept;
    logic                   last_word;
    logic                   job_last;

    assign accept     = (state == LOAD) && bus.s_valid;
    // Round 0 fills a whole kernel column per PU; later rounds add only the bottom word.
    assign last_word  = (pu_idx == last_idx) && ((round != 6'd0) || (addr == last_addr));
    assign sticky_nxt = sticky | bus.pu_t_flag;
    assign job_last   = (round == (rounds_q - 6'd1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.cfg_start) state_nxt = LOAD;
            LOAD: if (accept && last_word) state_nxt = FIRE;
            FIRE: state_nxt = WAIT;
            WAIT: if (sticky_nxt == all_done) state_nxt = NEXT;
            NEXT: state_nxt = job_last ? DONE : LOAD;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            round    <= 6'd0;
            rounds_q <= 6'd0;
            pu_idx   <= '0;
            addr     <= '0;
            sticky   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cfg_start) begin
                        rounds_q <= (bus.cfg_rounds == 6'd0) ? 6'd1 : bus.cfg_rounds;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        if (last_word) begin
                            pu_idx <= '0;
                            addr   <= '0;
                        end else if (round != 6'd0) begin
                            pu_idx <= pu_idx + 1'b1;
                        end else if (addr == last_addr) begin
                            addr   <= '0;
                            pu_idx <= pu_idx + 1'b1;
                        end else begin
                            addr <= addr + 1'b1;
                        end
                    end
                end
                // Flags seen during FIRE belong to no round yet; the clear discards them.
                FIRE: sticky <= '0;
                WAIT: sticky <= sticky_nxt;
                NEXT: round  <= job_last ? 6'd0 : (round + 6'd1);
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.s_ready           = 1'b0;
        bus.pu_new1           = '0;
        bus.pu_wr_g           = '0;
        bus.pu_adrs_in1       = '0;
        bus.pu_adrs_in2       = last_addr;
        bus.pu_start          = 1'b0;
        bus.pu_round          = round;
        bus.pu_act            = (state != IDLE);
        bus.pu_neighbour_flag = 1'b0;
        bus.busy              = (state != IDLE);
        bus.done              = (state == DONE);
        if (state == LOAD) begin
            bus.s_ready = 1'b1;
        end
        if (accept) begin
            bus.pu_new1     = bus.s_data;
            bus.pu_wr_g     = pu0_sel << pu_idx;
            bus.pu_adrs_in1 = (round == 6'd0) ? addr : last_addr;
        end
        if (state == FIRE) begin
            bus.pu_start          = 1'b1;
            bus.pu_neighbour_flag = (round != 6'd0);
        end
    end
endmodule
